// File: rtl/tk1_bus_pkg.sv
// Shared constants for the tk1 memory map and the CPU bus guard.
// The top-level address decoder uses the same area prefixes.
package tk1_bus_pkg;

    // Top-level address areas, selected by addr[31:30].
    localparam logic [1:0] AREA_ROM      = 2'h0;
    localparam logic [1:0] AREA_RAM      = 2'h1;
    localparam logic [1:0] AREA_RESERVED = 2'h2;
    localparam logic [1:0] AREA_MMIO     = 2'h3;

    // Core prefix within MMIO (addr[29:24]) that selects firmware RAM.
    localparam logic [5:0] FW_RAM_PREFIX = 6'h10;

    // Data returned to the CPU on a blocked or timed-out access.
    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'h0000_0000;

    // Guard FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } guard_state_e;

    // Area selector taken from the top address byte.
    function automatic logic [1:0] addr_area(input logic [7:0] addr_hi);
        return addr_hi[7:6];
    endfunction

    // True when the top address byte selects firmware RAM (0xD0xx_xxxx).
    function automatic logic is_fw_ram(input logic [7:0] addr_hi);
        return (addr_hi == {AREA_MMIO, FW_RAM_PREFIX});
    endfunction

endpackage

// File: rtl/cpu_bus_guard_if.sv
// Simple valid/ready memory bus as used by the picorv32 memory port.
// The master issues requests; the slave returns one ready strobe with data.
interface cpu_bus_guard_if;
    logic        valid;
    logic        instr;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;

    modport master (
        output valid, instr, addr, wstrb, wdata,
        input  ready, rdata
    );

    modport slave (
        input  valid, instr, addr, wstrb, wdata,
        output ready, rdata
    );
endinterface

// File: rtl/cpu_bus_guard_policy.sv
// Combinational access-policy check for the bus guard.
// Only the top address byte matters for the policy, so only it is passed in.
module bus_guard_policy
    import tk1_bus_pkg::*;
(
    input  logic [7:0] addr_hi,
    input  logic [3:0] wstrb,
    input  logic       instr,
    input  logic       fw_app_mode,
    output logic       blocked
);

    logic rom_s;
    logic mmio_s;
    logic fw_ram_s;
    logic write_s;

    // Classify the access and combine the four blocking rules.
    always_comb begin
        rom_s    = (addr_area(addr_hi) == AREA_ROM);
        mmio_s   = (addr_area(addr_hi) == AREA_MMIO);
        fw_ram_s = is_fw_ram(addr_hi);
        write_s  = (wstrb != 4'h0);
        blocked  = (rom_s && write_s)          // ROM is never writable
                || (fw_app_mode && rom_s)      // apps cannot touch ROM at all
                || (fw_app_mode && fw_ram_s)   // apps cannot touch firmware RAM
                || (instr && mmio_s);          // no execution from MMIO
    end

endmodule

// File: rtl/cpu_bus_guard.sv
// Registered request stage between the CPU memory port and the address
// decode / read-data mux. Blocks disallowed accesses, bounds every device
// access with a timeout, and keeps sticky fault status for software.
module cpu_bus_guard
    import tk1_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_WIDTH      = 8,
    parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fw_app_mode,
    input  logic                 clear_status,
    cpu_bus_guard_if.slave       cpu_bus,
    cpu_bus_guard_if.master      dev_bus,
    output logic                 violation,
    output logic                 timeout,
    output logic [CNT_WIDTH-1:0] violation_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE      = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX      = {CNT_WIDTH{1'b1}};
    // The counter is cleared when dev_valid rises, so the last waiting
    // cycle before abort is the one where it holds TIMEOUT_CYCLES-1.
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 32'd1);

    guard_state_e         state_q, state_d;
    logic [31:0]          addr_q, addr_d;
    logic [3:0]           wstrb_q, wstrb_d;
    logic [31:0]          wdata_q, wdata_d;
    logic                 instr_q, instr_d;
    logic                 dev_valid_q, dev_valid_d;
    logic                 cpu_ready_q, cpu_ready_d;
    logic [31:0]          cpu_rdata_q, cpu_rdata_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 violation_q, violation_d;
    logic                 timeout_q, timeout_d;
    logic [CNT_WIDTH-1:0] vcount_q, vcount_d;

    logic                 blocked_s;
    logic                 viol_event_s;
    logic                 tout_event_s;
    logic                 viol_base_s;
    logic                 tout_base_s;
    logic [CNT_WIDTH-1:0] vcount_base_s;

    bus_guard_policy u_policy (
        .addr_hi     (addr_q[31:24]),
        .wstrb       (wstrb_q),
        .instr       (instr_q),
        .fw_app_mode (fw_app_mode),
        .blocked     (blocked_s)
    );

    // Request FSM: latch, check policy, wait for device or timeout, respond.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wstrb_d      = wstrb_q;
        wdata_d      = wdata_q;
        instr_d      = instr_q;
        dev_valid_d  = 1'b0;
        cpu_ready_d  = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        cnt_d        = cnt_q;
        viol_event_s = 1'b0;
        tout_event_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cpu_bus.valid) begin
                    addr_d  = cpu_bus.addr;
                    wstrb_d = cpu_bus.wstrb;
                    wdata_d = cpu_bus.wdata;
                    instr_d = cpu_bus.instr;
                    state_d = ST_CHECK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (blocked_s) begin
                    cpu_rdata_d  = ERR_RDATA;
                    cpu_ready_d  = 1'b1;
                    viol_event_s = 1'b1;
                    state_d      = ST_RESP;
                end else begin
                    dev_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A ready in the limit cycle still completes normally.
                if (dev_bus.ready) begin
                    cpu_rdata_d = dev_bus.rdata;
                    cpu_ready_d = 1'b1;
                    state_d     = ST_RESP;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    cpu_rdata_d  = ERR_RDATA;
                    cpu_ready_d  = 1'b1;
                    tout_event_s = 1'b1;
                    state_d      = ST_RESP;
                end else begin
                    dev_valid_d = 1'b1;
                    cnt_d       = cnt_q + CNT_ONE;
                    state_d     = ST_WAIT;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sticky status: clear first, then let a same-cycle event set it again.
    always_comb begin
        viol_base_s   = clear_status ? 1'b0 : violation_q;
        tout_base_s   = clear_status ? 1'b0 : timeout_q;
        vcount_base_s = clear_status ? '0   : vcount_q;
        violation_d   = viol_event_s ? 1'b1 : viol_base_s;
        timeout_d     = tout_event_s ? 1'b1 : tout_base_s;
        if (!viol_event_s) begin
            vcount_d = vcount_base_s;
        end else if (vcount_base_s == CNT_MAX) begin
            vcount_d = CNT_MAX;
        end else begin
            vcount_d = vcount_base_s + CNT_ONE;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wstrb_q     <= '0;
            wdata_q     <= '0;
            instr_q     <= 1'b0;
            dev_valid_q <= 1'b0;
            cpu_ready_q <= 1'b0;
            cpu_rdata_q <= '0;
            cnt_q       <= '0;
            violation_q <= 1'b0;
            timeout_q   <= 1'b0;
            vcount_q    <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wstrb_q     <= wstrb_d;
            wdata_q     <= wdata_d;
            instr_q     <= instr_d;
            dev_valid_q <= dev_valid_d;
            cpu_ready_q <= cpu_ready_d;
            cpu_rdata_q <= cpu_rdata_d;
            cnt_q       <= cnt_d;
            violation_q <= violation_d;
            timeout_q   <= timeout_d;
            vcount_q    <= vcount_d;
        end
    end

    assign cpu_bus.ready   = cpu_ready_q;
    assign cpu_bus.rdata   = cpu_rdata_q;
    assign dev_bus.valid   = dev_valid_q;
    assign dev_bus.instr   = instr_q;
    assign dev_bus.addr    = addr_q;
    assign dev_bus.wstrb   = wstrb_q;
    assign dev_bus.wdata   = wdata_q;
    assign violation       = violation_q;
    assign timeout         = timeout_q;
    assign violation_count = vcount_q;

endmodule

// File: tb/tb_cpu_bus_guard.sv
// Directed and randomized bench for cpu_bus_guard. Expected results come
// from the access rules and latency figures, not from the design internals.
module tb_cpu_bus_guard;

    localparam int          T       = 4;
    localparam logic [31:0] ERR_VAL = 32'hE11E_0BAD;

    logic       clk;
    logic       reset;
    logic       fw_app_mode;
    logic       clear_status;
    logic       violation;
    logic       timeout;
    logic [7:0] violation_count;

    cpu_bus_guard_if cpu_if ();
    cpu_bus_guard_if dev_if ();

    cpu_bus_guard #(
        .TIMEOUT_CYCLES (T),
        .CNT_WIDTH      (8),
        .ERR_RDATA      (ERR_VAL)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .fw_app_mode     (fw_app_mode),
        .clear_status    (clear_status),
        .cpu_bus         (cpu_if),
        .dev_bus         (dev_if),
        .violation       (violation),
        .timeout         (timeout),
        .violation_count (violation_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference status
    bit m_viol;
    bit m_tout;
    int m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit model_blocked(input logic [31:0] a, input logic [3:0] ws,
                                         input bit ins, input bit mode);
        bit rom;
        bit mmio;
        bit fwram;
        rom   = (a < 32'h4000_0000);
        mmio  = (a >= 32'hC000_0000);
        fwram = (a >= 32'hD000_0000) && (a < 32'hD100_0000);
        return (rom && ws != 4'h0) || (mode && rom) || (mode && fwram) || (ins && mmio);
    endfunction

    // ready_at: dev_valid cycle (1-based) in which dev_ready is given; 0 = never.
    task automatic do_txn(input logic [31:0] addr, input logic [3:0] ws, input bit ins,
                          input bit mode, input int ready_at, input logic [31:0] rd,
                          input bit clr, input string tag);
        bit          blk;
        bit          exp_to;
        int          exp_dv;
        int          exp_k;
        logic [31:0] exp_rd;
        logic [31:0] wd;
        int          dv;
        int          resp_k;
        bit          unstable;
        logic [31:0] got_rd;
        logic        dv_at_resp;

        blk    = model_blocked(addr, ws, ins, mode);
        exp_to = !blk && !(ready_at >= 1 && ready_at <= T);
        exp_dv = blk ? 0 : (exp_to ? T : ready_at);
        exp_k  = blk ? 2 : exp_dv + 2;
        exp_rd = (blk || exp_to) ? ERR_VAL : rd;
        if (clr) begin
            m_viol = 1'b0;
            m_tout = 1'b0;
            m_cnt  = 0;
        end
        if (blk) begin
            m_viol = 1'b1;
            if (m_cnt < 255) m_cnt++;
        end
        if (exp_to) m_tout = 1'b1;

        wd = $urandom;
        cpu_if.valid  = 1'b1;
        cpu_if.addr   = addr;
        cpu_if.wstrb  = ws;
        cpu_if.wdata  = wd;
        cpu_if.instr  = ins;
        fw_app_mode   = mode;
        clear_status  = 1'b0;
        dev_if.ready  = 1'($urandom_range(0, 1));  // ignored while idle
        dev_if.rdata  = $urandom;

        dv = 0; resp_k = -1; unstable = 1'b0; got_rd = '0; dv_at_resp = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            step();
            dev_if.ready = 1'b0;
            clear_status = (k == 1) ? clr : 1'b0;
            if (k >= 2) fw_app_mode = 1'($urandom_range(0, 1));
            if (cpu_if.ready) begin
                resp_k     = k;
                got_rd     = cpu_if.rdata;
                dv_at_resp = dev_if.valid;
                break;
            end
            if (dev_if.valid) begin
                dv++;
                if (dev_if.addr !== addr || dev_if.wstrb !== ws || dev_if.wdata !== wd)
                    unstable = 1'b1;
                if (dv == ready_at) begin
                    dev_if.ready = 1'b1;
                    dev_if.rdata = rd;
                end
            end
        end
        cpu_if.valid = 1'b0;
        clear_status = 1'b0;

        chk({tag, "_resp_cycle"}, resp_k, exp_k);
        chk({tag, "_rdata"}, got_rd, exp_rd);
        chk({tag, "_dev_valid_cycles"}, dv, exp_dv);
        chk({tag, "_dev_stable"}, {31'd0, unstable}, 32'd0);
        chk({tag, "_dev_valid_at_resp"}, {31'd0, dv_at_resp}, 32'd0);
        chk({tag, "_violation"}, {31'd0, violation}, {31'd0, m_viol});
        chk({tag, "_timeout"}, {31'd0, timeout}, {31'd0, m_tout});
        chk({tag, "_vcount"}, {24'd0, violation_count}, m_cnt);
        step();
        chk({tag, "_ready_one_cycle"}, {31'd0, cpu_if.ready}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] bases [6];
        logic [31:0] a;
        logic [3:0]  ws;

        bases[0] = 32'h0000_0000; bases[1] = 32'h4000_0000; bases[2] = 32'h8000_0000;
        bases[3] = 32'hC000_0000; bases[4] = 32'hD000_0000; bases[5] = 32'hD100_0000;

        reset = 1'b1; fw_app_mode = 1'b0; clear_status = 1'b0;
        cpu_if.valid = 1'b0; cpu_if.instr = 1'b0; cpu_if.addr = '0;
        cpu_if.wstrb = '0; cpu_if.wdata = '0;
        dev_if.ready = 1'b0; dev_if.rdata = '0;
        m_viol = 1'b0; m_tout = 1'b0; m_cnt = 0;
        repeat (3) step();
        chk("rst_cpu_ready", {31'd0, cpu_if.ready}, 32'd0);
        chk("rst_cpu_rdata", cpu_if.rdata, 32'd0);
        chk("rst_dev_valid", {31'd0, dev_if.valid}, 32'd0);
        chk("rst_dev_addr", dev_if.addr, 32'd0);
        chk("rst_violation", {31'd0, violation}, 32'd0);
        chk("rst_vcount", {24'd0, violation_count}, 32'd0);
        reset = 1'b0;
        step();

        do_txn(32'h4000_0010, 4'h0, 1'b0, 1'b0, 3, 32'hDEAD_BEEF, 1'b0, "fw_ram_read");
        do_txn(32'h0000_0100, 4'h0, 1'b0, 1'b1, 1, 32'h1234_5678, 1'b0, "app_rom_read");
        do_txn(32'h0000_0000, 4'hF, 1'b0, 1'b0, 1, 32'h1111_1111, 1'b1, "rom_write");
        do_txn(32'hC000_0000, 4'h0, 1'b1, 1'b0, 1, 32'h2222_2222, 1'b0, "mmio_fetch");
        do_txn(32'h0000_0040, 4'h0, 1'b1, 1'b0, 2, 32'h3333_3333, 1'b0, "fw_rom_fetch");
        do_txn(32'hC100_0000, 4'h0, 1'b0, 1'b0, 0, 32'h4444_4444, 1'b0, "hang_timeout");
        do_txn(32'hC100_0000, 4'h0, 1'b0, 1'b0, T, 32'h5555_5555, 1'b1, "ready_at_limit");
        do_txn(32'hD000_0004, 4'h0, 1'b0, 1'b1, 1, 32'h6666_6666, 1'b0, "app_fw_ram");
        do_txn(32'hD000_0004, 4'h3, 1'b0, 1'b0, 2, 32'h7777_7777, 1'b0, "fw_fw_ram_wr");
        do_txn(32'hD0FF_FFFC, 4'h0, 1'b0, 1'b1, 1, 32'h8888_8888, 1'b0, "app_fw_ram_top");
        do_txn(32'hD100_0000, 4'h0, 1'b0, 1'b1, 1, 32'h9999_9999, 1'b0, "app_mmio_next");
        do_txn(32'h3FFF_FFFC, 4'h0, 1'b0, 1'b1, 1, 32'hAAAA_AAAA, 1'b0, "app_rom_top");

        for (int i = 0; i < 60; i++) begin
            a  = bases[$urandom_range(0, 5)] | ($urandom & 32'h00FF_FFFF);
            ws = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            do_txn(a, ws, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 6), $urandom, ($urandom_range(0, 7) == 0),
                   $sformatf("rand%0d", i));
        end

        for (int i = 0; i < 300; i++)
            do_txn(32'h0000_0200, 4'h1, 1'b0, 1'b0, 1, 32'h0, (i == 0), "saturate");
        chk("sat_final_vcount", {24'd0, violation_count}, 32'h0000_00FF);
        do_txn(32'h0000_0200, 4'h1, 1'b0, 1'b0, 1, 32'h0, 1'b1, "clear_with_violation");
        chk("clear_vcount_one", {24'd0, violation_count}, 32'd1);

        // Reset in the middle of a device wait
        do_txn(32'hC100_0000, 4'h0, 1'b0, 1'b0, 0, 32'h0, 1'b0, "pre_reset_timeout");
        cpu_if.valid = 1'b1; cpu_if.addr = 32'h4000_0020; cpu_if.wstrb = 4'h0;
        cpu_if.instr = 1'b0; fw_app_mode = 1'b0;
        step(); step();
        chk("wait_dev_valid", {31'd0, dev_if.valid}, 32'd1);
        reset = 1'b1; cpu_if.valid = 1'b0;
        step();
        chk("midrst_dev_valid", {31'd0, dev_if.valid}, 32'd0);
        chk("midrst_dev_addr", dev_if.addr, 32'd0);
        chk("midrst_violation", {31'd0, violation}, 32'd0);
        chk("midrst_timeout", {31'd0, timeout}, 32'd0);
        chk("midrst_vcount", {24'd0, violation_count}, 32'd0);
        chk("midrst_cpu_rdata", cpu_if.rdata, 32'd0);
        reset = 1'b0;
        m_viol = 1'b0; m_tout = 1'b0; m_cnt = 0;
        do_txn(32'h4000_0100, 4'h0, 1'b0, 1'b0, 2, 32'hCAFE_F00D, 1'b0, "post_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
